// File: rtl/register_file.sv
// Multi-port register file (2 read, 1 write) with register 0 hardwired to zero and a clear sweep.
// Defining RF_BYPASS_EN forwards an accepted write straight to a matching read port.
module register_file #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             WE,
    input  logic [AW-1:0]    Awr,
    input  logic [WIDTH-1:0] Din,
    input  logic [AW-1:0]    Ard1,
    input  logic [AW-1:0]    Ard2,
    output logic [WIDTH-1:0] Dout1,
    output logic [WIDTH-1:0] Dout2,
    input  logic             Clr,
    output logic             Busy,
    output logic [0:0]       dbg_state
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [0:0]       state;
    logic [AW-1:0]    cnt;
    logic             wr_en;

    assign Busy      = (state == SWEEP);
    assign dbg_state = state;
    assign wr_en     = WE && !Busy && (Awr != '0);

    // Register 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        regs[Awr] <= Din;
                    end
                    if (Clr) begin
                        state <= SWEEP;
                        cnt   <= AW'(1);
                    end
                end
                SWEEP: begin
                    regs[cnt] <= '0;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        Dout1 = regs[Ard1];
        Dout2 = regs[Ard2];
`ifdef RF_BYPASS_EN
        if (wr_en && (Ard1 == Awr)) begin
            Dout1 = Din;
        end
        if (wr_en && (Ard2 == Awr)) begin
            Dout2 = Din;
        end
`else
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference model.
module tb_register_file;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             Clk;
    logic             Rst;
    logic             WE;
    logic [AW-1:0]    Awr;
    logic [WIDTH-1:0] Din;
    logic [AW-1:0]    Ard1;
    logic [AW-1:0]    Ard2;
    logic [WIDTH-1:0] Dout1;
    logic [WIDTH-1:0] Dout2;
    logic             Clr;
    logic             Busy;
    logic [0:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] mem [DEPTH];
    bit               m_busy;
    int               m_next;

    register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .WE(WE), .Awr(Awr), .Din(Din),
        .Ard1(Ard1), .Ard2(Ard2), .Dout1(Dout1), .Dout2(Dout2),
        .Clr(Clr), .Busy(Busy), .dbg_state(dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        m_busy = 0;
        m_next = 0;
    endfunction

    // Applies the effect of the coming rising edge, given the inputs currently driven.
    function automatic void model_edge();
        if (m_busy) begin
            mem[m_next] = '0;
            if (m_next == DEPTH - 1) m_busy = 0;
            else m_next = m_next + 1;
        end else begin
            if (WE && Awr != 0) mem[Awr] = Din;
            if (Clr) begin
                m_busy = 1;
                m_next = 1;
            end
        end
    endfunction

    function automatic logic [WIDTH-1:0] exp_read(input logic [AW-1:0] a);
`ifdef RF_BYPASS_EN
        if (!m_busy && WE && Awr != 0 && a == Awr) return Din;
`endif
        return mem[a];
    endfunction

    task automatic tick();
        model_edge();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_ports(input string tag);
        #1;
        check({tag, "_dout1"}, Dout1, exp_read(Ard1));
        check({tag, "_dout2"}, Dout2, exp_read(Ard2));
        check({tag, "_busy"}, WIDTH'(Busy), WIDTH'(m_busy));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        WE = 1'b1; Awr = a; Din = d;
        tick();
        WE = 1'b0;
    endtask

    task automatic fill_nonzero();
        for (int i = 1; i < DEPTH; i++) wr(AW'(i), $urandom() | 32'h1);
    endtask

    initial begin
        int busy_cnt;
        Rst = 1'b0; WE = 1'b0; Awr = '0; Din = '0; Ard1 = '0; Ard2 = '0; Clr = 1'b0;
        model_reset();
        @(negedge Clk);
        #1;
        check("reset_busy", WIDTH'(Busy), '0);
        @(negedge Clk);
        Rst = 1'b1;

        // Every address reads zero after reset.
        for (int a = 0; a < DEPTH; a++) begin
            Ard1 = AW'(a); Ard2 = AW'(DEPTH - 1 - a);
            #1;
            check("reset_rd1", Dout1, '0);
            check("reset_rd2", Dout2, '0);
        end
        @(negedge Clk);

        wr(5, 32'hFFFF_FFFF);
        wr(6, 32'hF0F0_F0F0);
        Ard1 = 5; Ard2 = 6;
        #1;
        check("wr5", Dout1, 32'hFFFF_FFFF);
        check("wr6", Dout2, 32'hF0F0_F0F0);
        wr(0, 32'h1234);
        Ard1 = 0; Ard2 = 0;
        #1;
        check("wr0_p1", Dout1, '0);
        check("wr0_p2", Dout2, '0);

        wr(7, 32'h1111_2222);
        WE = 1'b1; Awr = 7; Din = 32'hA5A5_A5A5; Ard1 = 7; Ard2 = 6;
        #1;
`ifdef RF_BYPASS_EN
        check("bypass_same_cycle", Dout1, 32'hA5A5_A5A5);
`else
        check("no_bypass_old", Dout1, 32'h1111_2222);
`endif
        tick();
        WE = 1'b0;
        #1;
        check("after_wr7", Dout1, 32'hA5A5_A5A5);

        // Directed sweep with a dropped write and an ignored second clear.
        fill_nonzero();
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 100 && Busy; c++) begin
            busy_cnt++;
            Ard1 = 3; Ard2 = 31;
            if (c == 5) begin
                WE = 1'b1; Awr = 31; Din = 32'hDEAD; Clr = 1'b1;
            end
            check_ports("sweep");
            tick();
            WE = 1'b0; Clr = 1'b0;
        end
        check("sweep_len", WIDTH'(busy_cnt), WIDTH'(DEPTH - 1));
        for (int a = 0; a < DEPTH; a++) begin
            Ard1 = AW'(a); Ard2 = AW'(a);
            #1;
            check("post_sweep", Dout1, '0);
        end
        @(negedge Clk);

        // Reset in the middle of a sweep.
        fill_nonzero();
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        Ard1 = 20; Ard2 = 31;
        #1;
        check("pre_abort_rd", Dout1, mem[20]);
        Rst = 1'b0;
        model_reset();
        #1;
        check("abort_busy", WIDTH'(Busy), '0);
        check("abort_rd1", Dout1, '0);
        check("abort_rd2", Dout2, '0);
        @(negedge Clk);
        Rst = 1'b1;
        wr(9, 32'h0BAD_F00D);
        Ard1 = 9;
        #1;
        check("wr_after_abort", Dout1, 32'h0BAD_F00D);
        @(negedge Clk);

        // Random traffic with occasional clears.
        for (int c = 0; c < 400; c++) begin
            WE   = 1'($urandom_range(0, 1));
            Awr  = AW'($urandom_range(0, DEPTH - 1));
            Din  = $urandom();
            Ard1 = AW'($urandom_range(0, DEPTH - 1));
            Ard2 = ($urandom_range(0, 3) == 0) ? Ard1 : AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) == 0) Ard1 = Awr;
            Clr  = ($urandom_range(0, 39) == 0);
            check_ports("rand");
            tick();
        end
        WE = 1'b0; Clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
